// File: rtl/cook_sequencer.sv
// Microwave cook-cycle controller: keypad entry into a BCD M:ST:SO timer, an
// IDLE/COOK/PAUSE/DONE sequence and a once-per-second countdown while cooking.
module cook_sequencer #(
  parameter int TICK_DIV = 100000,
  parameter int TICK_W   = 17
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [9:0]  keypad,
  input  logic        startn,
  input  logic        stopn,
  input  logic        clearn,
  input  logic        door_closed,
  output logic [3:0]  mins,
  output logic [3:0]  sec_tens,
  output logic [3:0]  sec_ones,
  output logic        mag_on,
  output logic        done,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {IDLE = 2'd0, COOK = 2'd1, PAUSE = 2'd2, DONE = 2'd3} state_t;

  state_t              state_q, state_d;
  logic [3:0]          mins_d, sec_tens_d, sec_ones_d;
  logic [TICK_W-1:0]   pre_q, pre_d;
  logic                startn_q, stopn_q, clearn_q;
  logic [9:0]          keypad_q;
  logic                start_ev, stop_ev, clear_ev, key_ev, key_onehot;
  logic [3:0]          key_digit;

  // Button history resets to "released" (high) so a button held through
  // reset does not fire an event when reset drops.
  assign start_ev   = startn_q & ~startn;
  assign stop_ev    = stopn_q  & ~stopn;
  assign clear_ev   = clearn_q & ~clearn;
  assign key_onehot = (keypad != 10'd0) && ((keypad & (keypad - 10'd1)) == 10'd0);
  assign key_ev     = (keypad_q == 10'd0) && key_onehot;

  always_comb begin
    key_digit = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (keypad[i]) key_digit = 4'(i);
    end
  end

  always_comb begin
    state_d    = state_q;
    mins_d     = mins;
    sec_tens_d = sec_tens;
    sec_ones_d = sec_ones;
    pre_d      = pre_q;
    if (clear_ev) begin
      state_d    = IDLE;
      mins_d     = 4'd0;
      sec_tens_d = 4'd0;
      sec_ones_d = 4'd0;
      pre_d      = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (stop_ev) begin
            state_d = IDLE;
          end else if (start_ev) begin
            if (door_closed && ({mins, sec_tens, sec_ones} != 12'd0)) begin
              state_d = COOK;
              pre_d   = '0;
            end
          end else if (key_ev) begin
            mins_d     = sec_tens;
            sec_tens_d = sec_ones;
            sec_ones_d = key_digit;
          end
        end
        COOK: begin
          // Pausing beats a coincident tick; the partial second is held.
          if (!door_closed || stop_ev) begin
            state_d = PAUSE;
          end else if (pre_q == TICK_W'(TICK_DIV - 1)) begin
            pre_d = '0;
            if (sec_ones != 4'd0) begin
              sec_ones_d = sec_ones - 4'd1;
            end else if (sec_tens != 4'd0) begin
              sec_tens_d = sec_tens - 4'd1;
              sec_ones_d = 4'd9;
            end else begin
              mins_d     = mins - 4'd1;
              sec_tens_d = 4'd5;
              sec_ones_d = 4'd9;
            end
            if ({mins_d, sec_tens_d, sec_ones_d} == 12'd0) state_d = DONE;
          end else begin
            pre_d = pre_q + TICK_W'(1);
          end
        end
        PAUSE: begin
          if (!door_closed) begin
            state_d = PAUSE;
          end else if (stop_ev) begin
            state_d = IDLE;
          end else if (start_ev) begin
            state_d = COOK;
            pre_d   = '0;
          end
        end
        DONE: begin
          if (!door_closed || stop_ev || start_ev || key_ev) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      mins     <= 4'd0;
      sec_tens <= 4'd0;
      sec_ones <= 4'd0;
      pre_q    <= '0;
      startn_q <= 1'b1;
      stopn_q  <= 1'b1;
      clearn_q <= 1'b1;
      keypad_q <= 10'd0;
      done     <= 1'b0;
    end else begin
      state_q  <= state_d;
      mins     <= mins_d;
      sec_tens <= sec_tens_d;
      sec_ones <= sec_ones_d;
      pre_q    <= pre_d;
      startn_q <= startn;
      stopn_q  <= stopn;
      clearn_q <= clearn;
      keypad_q <= keypad;
      done     <= (state_d == DONE);
    end
  end

  assign state  = state_q;
  assign mag_on = (state_q == COOK) && door_closed;

endmodule

// File: tb/tb_cook_sequencer.sv
// Directed bench for cook_sequencer with TICK_DIV=4: a per-cycle vector table
// for keypad entry and start gating, then hand-written multi-cycle sequences.
module tb_cook_sequencer;

  localparam logic [1:0] S_IDLE = 2'd0, S_COOK = 2'd1, S_PAUSE = 2'd2, S_DONE = 2'd3;

  logic       clock = 1'b0;
  logic       reset;
  logic [9:0] keypad;
  logic       startn, stopn, clearn, door_closed;
  logic [3:0] mins, sec_tens, sec_ones;
  logic       mag_on, done;
  logic [1:0] state;

  int n_checks = 0;
  int n_fails  = 0;

  cook_sequencer #(.TICK_DIV(4), .TICK_W(3)) dut (
    .clock(clock), .reset(reset), .keypad(keypad), .startn(startn), .stopn(stopn),
    .clearn(clearn), .door_closed(door_closed), .mins(mins), .sec_tens(sec_tens),
    .sec_ones(sec_ones), .mag_on(mag_on), .done(done), .state(state)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [9:0] kp;
    logic       s, p, c, d;
    logic [3:0] m, st, so;
    logic [1:0] stt;
    logic       mag, dn;
  } vec_t;

  vec_t vecs[17];

  task automatic check(input string name, input logic [3:0] m, input logic [3:0] st,
                       input logic [3:0] so, input logic [1:0] stt, input logic mag,
                       input logic dn);
    logic [15:0] act, exp;
    act = {mins, sec_tens, sec_ones, state, mag_on, done};
    exp = {m, st, so, stt, mag, dn};
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h:%h:%h state=%0d mag_on=%b done=%b, expected %h:%h:%h state=%0d mag_on=%b done=%b",
               name, mins, sec_tens, sec_ones, state, mag_on, done, m, st, so, stt, mag, dn);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic press_key(input int d);
    keypad = 10'(1 << d);
    cycles(2);
    keypad = 10'd0;
    cycles(1);
  endtask

  task automatic pulse_start();
    startn = 1'b0;
    cycles(1);
    startn = 1'b1;
  endtask

  initial begin
    // kp, startn, stopn, clearn, door | mins, sec_tens, sec_ones, state, mag_on, done
    vecs[0]  = '{10'd0,      1, 1, 1, 1, 0, 0, 0, S_IDLE, 0, 0};
    vecs[1]  = '{10'h008,    1, 1, 1, 1, 0, 0, 3, S_IDLE, 0, 0};
    vecs[2]  = '{10'h008,    1, 1, 1, 1, 0, 0, 3, S_IDLE, 0, 0};
    vecs[3]  = '{10'd0,      1, 1, 1, 1, 0, 0, 3, S_IDLE, 0, 0};
    vecs[4]  = '{10'h020,    1, 1, 1, 1, 0, 3, 5, S_IDLE, 0, 0};
    vecs[5]  = '{10'h020,    1, 1, 1, 1, 0, 3, 5, S_IDLE, 0, 0};
    vecs[6]  = '{10'd0,      1, 1, 1, 1, 0, 3, 5, S_IDLE, 0, 0};
    vecs[7]  = '{10'h003,    1, 1, 1, 1, 0, 3, 5, S_IDLE, 0, 0};
    vecs[8]  = '{10'd0,      1, 1, 1, 1, 0, 3, 5, S_IDLE, 0, 0};
    vecs[9]  = '{10'h200,    1, 1, 1, 1, 3, 5, 9, S_IDLE, 0, 0};
    vecs[10] = '{10'h200,    1, 1, 1, 1, 3, 5, 9, S_IDLE, 0, 0};
    vecs[11] = '{10'd0,      1, 1, 1, 1, 3, 5, 9, S_IDLE, 0, 0};
    vecs[12] = '{10'd0,      1, 1, 1, 0, 3, 5, 9, S_IDLE, 0, 0};
    vecs[13] = '{10'd0,      0, 1, 1, 0, 3, 5, 9, S_IDLE, 0, 0};
    vecs[14] = '{10'd0,      1, 1, 1, 0, 3, 5, 9, S_IDLE, 0, 0};
    vecs[15] = '{10'd0,      1, 1, 1, 1, 3, 5, 9, S_IDLE, 0, 0};
    vecs[16] = '{10'd0,      0, 1, 1, 1, 3, 5, 9, S_COOK, 1, 0};

    reset = 1'b1; keypad = 10'd0; startn = 1'b1; stopn = 1'b1; clearn = 1'b1;
    door_closed = 1'b1;
    cycles(3);
    check("reset", 0, 0, 0, S_IDLE, 0, 0);
    reset = 1'b0;

    for (int i = 0; i < 17; i++) begin
      keypad = vecs[i].kp; startn = vecs[i].s; stopn = vecs[i].p;
      clearn = vecs[i].c;  door_closed = vecs[i].d;
      cycles(1);
      check($sformatf("vec%0d", i), vecs[i].m, vecs[i].st, vecs[i].so, vecs[i].stt,
            vecs[i].mag, vecs[i].dn);
    end
    startn = 1'b1;

    // Countdown: first tick 4 cycles after entry, then one every 4 cycles.
    cycles(3);
    check("pre_first_tick", 3, 5, 9, S_COOK, 1, 0);
    cycles(1);
    check("first_tick", 3, 5, 8, S_COOK, 1, 0);
    cycles(58 * 4);
    check("reach_300", 3, 0, 0, S_COOK, 1, 0);
    cycles(4);
    check("min_borrow", 2, 5, 9, S_COOK, 1, 0);
    cycles(14 * 4);
    check("reach_245", 2, 4, 5, S_COOK, 1, 0);

    // Door opens: magnetron drops before the state register moves.
    door_closed = 1'b0;
    #1 check("door_mag_comb", 2, 4, 5, S_COOK, 0, 0);
    cycles(1);
    check("door_pause", 2, 4, 5, S_PAUSE, 0, 0);
    cycles(20);
    check("pause_frozen", 2, 4, 5, S_PAUSE, 0, 0);
    door_closed = 1'b1;
    pulse_start();
    check("resume", 2, 4, 5, S_COOK, 1, 0);
    cycles(3);
    check("resume_no_tick", 2, 4, 5, S_COOK, 1, 0);
    cycles(1);
    check("resume_tick", 2, 4, 4, S_COOK, 1, 0);

    // Stop pauses; holding it does not repeat into IDLE.
    stopn = 1'b0;
    cycles(1);
    check("stop_pause", 2, 4, 4, S_PAUSE, 0, 0);
    cycles(10);
    check("stop_held", 2, 4, 4, S_PAUSE, 0, 0);
    stopn = 1'b1;
    cycles(1);
    clearn = 1'b0;
    cycles(1);
    clearn = 1'b1;
    check("clear", 0, 0, 0, S_IDLE, 0, 0);
    pulse_start();
    check("start_zero", 0, 0, 0, S_IDLE, 0, 0);

    // Short cook to DONE, then a key only returns to IDLE.
    press_key(2);
    check("enter_002", 0, 0, 2, S_IDLE, 0, 0);
    pulse_start();
    check("cook_002", 0, 0, 2, S_COOK, 1, 0);
    cycles(7);
    check("cook_001", 0, 0, 1, S_COOK, 1, 0);
    cycles(1);
    check("done", 0, 0, 0, S_DONE, 0, 1);
    keypad = 10'h080;
    cycles(1);
    check("done_key_exit", 0, 0, 0, S_IDLE, 0, 0);
    cycles(1);
    keypad = 10'd0;
    cycles(1);
    press_key(7);
    check("key7_after_done", 0, 0, 7, S_IDLE, 0, 0);

    // Reset in the middle of cooking.
    clearn = 1'b0; cycles(1); clearn = 1'b1;
    press_key(1); press_key(7); press_key(9);
    check("enter_179", 1, 7, 9, S_IDLE, 0, 0);
    pulse_start();
    check("cook_179", 1, 7, 9, S_COOK, 1, 0);
    cycles(2);
    reset = 1'b1;
    cycles(1);
    check("reset_mid_cook", 0, 0, 0, S_IDLE, 0, 0);
    reset = 1'b0;
    cycles(1);

    // Clear and start edges together: clear wins.
    press_key(5);
    check("enter_005", 0, 0, 5, S_IDLE, 0, 0);
    clearn = 1'b0; startn = 1'b0;
    cycles(1);
    check("clear_beats_start", 0, 0, 0, S_IDLE, 0, 0);
    clearn = 1'b1; startn = 1'b1;
    cycles(2);
    check("after_clear_start", 0, 0, 0, S_IDLE, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/cook_sequencer.md
Name: cook_sequencer

Overview:
Cook-cycle controller for the microwave oven. It accepts one-hot keypad digits into a three-digit BCD timer (M:ST:SO), sequences the IDLE/COOK/PAUSE/DONE flow from the active-low start, stop and clear buttons and the door switch, and counts the timer down once per second. It drives the magnetron enable and the BCD digits that feed the seven-segment decoders.

Parameters:
TICK_DIV, 100000, clock cycles per one-second countdown tick (minimum 2)
TICK_W, 17, prescaler width; must satisfy 2^TICK_W >= TICK_DIV

Ports:
clock  in  1  system clock; all state updates on its rising edge
reset  in  1  synchronous, active-high reset
keypad  in  10  one-hot digit keys; bit n set = digit n pressed (level)
startn  in  1  start button, active-low level
stopn  in  1  stop/pause button, active-low level
clearn  in  1  clear button, active-low level
door_closed  in  1  1 = door closed
mins  out  4  BCD minutes digit
sec_tens  out  4  BCD seconds-tens digit
sec_ones  out  4  BCD seconds-ones digit
mag_on  out  1  magnetron enable
done  out  1  cook cycle finished
state  out  2  0=IDLE, 1=COOK, 2=PAUSE, 3=DONE

Behaviour:
- Reset: state=IDLE; mins, sec_tens and sec_ones = 0; prescaler = 0; all edge-detect history registers = "released"; mag_on=0; done=0. Reset takes priority over every other input in any state.
- All inputs are already synchronised and debounced upstream.
- Event detection:
  - start_ev, stop_ev, clear_ev: registered falling edge of the respective n-input. Each event lasts exactly one cycle. Holding the button produces no repeats.
  - key_ev: previous keypad==0 and current keypad has exactly one bit set. The digit is that bit's index.
  - A keypad value with zero or two or more bits set is ignored and does not generate key_ev.
- Event priority, evaluated in the same cycle: clear_ev > door open > stop_ev > start_ev > key_ev > tick.
- clear_ev, any state: all digits = 0, state=IDLE, prescaler=0.
- IDLE:
  - key_ev shifts the digits left: mins<=sec_tens, sec_tens<=sec_ones, sec_ones<=digit. The old mins value is discarded.
  - Digits are stored raw, so sec_tens may hold 6-9.
  - start_ev with door_closed=1 and time != 000 moves to COOK and sets prescaler=0. Otherwise start_ev is ignored.
- COOK:
  - Keypad is ignored.
  - The prescaler increments every cycle. When it reaches TICK_DIV-1 it wraps to 0 and a tick occurs. The first tick is therefore TICK_DIV cycles after COOK entry.
  - Tick decrement rules:
    - If sec_ones != 0, then sec_ones-1.
    - Else if sec_tens != 0, then sec_tens-1 and sec_ones=9.
    - Else mins-1, sec_tens=5, sec_ones=9.
  - A tick that produces 000 moves the block to DONE in the same edge.
  - door_closed=0 or stop_ev moves to PAUSE. The prescaler is held.
- PAUSE:
  - Digits and prescaler are held. Keypad is ignored.
  - start_ev with door_closed=1 moves to COOK with prescaler=0, so the partial second restarts.
  - stop_ev moves to IDLE with the digits kept.
- DONE:
  - Digits stay 000.
  - Any of start_ev, key_ev, stop_ev, or door opening moves to IDLE. That event has no other effect: a key is not entered and a start does not start.
- mag_on = (state==COOK) & door_closed, combinational. It drops in the same cycle the door opens, before the state register updates.
- done = (state==DONE), registered.
- A tick in the same cycle as a door-open or stop_ev: the pause wins and no decrement occurs.
- Digit outputs are taken directly from registers, with no added latency.

Test Plan:
- TICK_DIV=4. Pulse keys 3, 5, 9 (each held 2+ cycles), door closed. Expect digits 3:5:9 after the third key_ev. Pulse startn low: state=COOK and mag_on=1 the cycle after the edge. 4 cycles later expect 3:5:8. At 3:0:0 the next tick gives 2:5:9.
- Door open, digits 3:5:9, pulse startn: state stays IDLE and mag_on=0. Close the door and pulse startn: COOK.
- Cooking at 2:4:5, drop door_closed: mag_on=0 the same cycle, state=PAUSE next cycle, digits frozen for 20 cycles. Close the door and pulse startn: resumes and the first decrement comes 4 cycles later.
- Cooking, pulse stopn: PAUSE. Hold stopn low for 10 cycles: no further event. Pulse clearn: digits 000, IDLE. Pulse startn: stays IDLE because time is 000.
- Enter 0:0:2 and start: after 8 cycles digits 000, state=DONE, done=1, mag_on=0. Press key 7: IDLE with digits still 000 and done=0. Press key 7 again: sec_ones=7.
- Keypad 0x003 (two bits): ignored. Assert reset mid-COOK at 1:7:9: next cycle all outputs 0, state IDLE. Simultaneous clearn and startn edges: clear wins.
